// File: rtl/pe_buf_pkg.sv
// Shared PE input-buffer types and modulo (DEPTH+1) pointer helpers, used by both reader and writer sides.
package pe_buf_pkg;

    localparam int unsigned PTR_W = 4;
    localparam int unsigned OCC_W = 5;

    // Encoding equals the number of words held in the read-side skid queue
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2
    } q_state_t;

    // ptr + inc modulo (depth+1), evaluated 5-bit so the sum never wraps early
    function automatic logic [PTR_W-1:0] ptr_add(
        input logic [PTR_W-1:0] ptr,
        input logic [OCC_W-1:0] inc,
        input logic [OCC_W-1:0] depth
    );
        logic [OCC_W-1:0] w_slots;
        logic [OCC_W-1:0] w_sum;
        w_slots = depth + OCC_W'(1);
        w_sum   = OCC_W'(ptr) + inc;
        if (w_sum >= w_slots) begin
            w_sum = w_sum - w_slots;
        end
        return w_sum[PTR_W-1:0];
    endfunction

    // Slots filled between raddr and waddr; waddr == raddr is empty
    function automatic logic [OCC_W-1:0] occ(
        input logic [PTR_W-1:0] waddr,
        input logic [PTR_W-1:0] raddr,
        input logic [OCC_W-1:0] depth
    );
        if (waddr >= raddr) begin
            return OCC_W'(waddr) - OCC_W'(raddr);
        end
        return OCC_W'(waddr) + depth + OCC_W'(1) - OCC_W'(raddr);
    endfunction

endpackage

// File: rtl/pe_buffer_read_port_if.sv
// Buffer-side and PE-stream signals of the PE buffer read port.
// PE_RD_STATS_EN adds the stall/starve counter outputs.
interface pe_buffer_read_port_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PAR_READ = 3
);
    logic [pe_buf_pkg::PTR_W-1:0] waddr;
    logic [pe_buf_pkg::PTR_W-1:0] raddr;
    logic                         rd_en;
    logic [WIDTH*PAR_READ-1:0]    buf_rdata;
    logic [WIDTH*PAR_READ-1:0]    m_data;
    logic                         m_valid;
    logic                         m_ready;
    logic [pe_buf_pkg::OCC_W-1:0] occupancy;
    logic                         empty;
`ifdef PE_RD_STATS_EN
    logic [15:0]                  stall_cnt;
    logic [15:0]                  starve_cnt;
`endif

    // Read-port side
    modport master (
        input  waddr, buf_rdata, m_ready,
`ifdef PE_RD_STATS_EN
        output stall_cnt, starve_cnt,
`endif
        output raddr, rd_en, m_data, m_valid, occupancy, empty
    );

    // Buffer / PE / writer side
    modport slave (
        output waddr, buf_rdata, m_ready,
`ifdef PE_RD_STATS_EN
        input  stall_cnt, starve_cnt,
`endif
        input  raddr, rd_en, m_data, m_valid, occupancy, empty
    );

endinterface

// File: rtl/pe_rd_skid_q.sv
// Two-entry output queue for the PE read port; head entry drives the stream, count kept as FSM state.
module pe_rd_skid_q
    import pe_buf_pkg::*;
#(
    parameter int unsigned DW = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_valid,
    output logic [1:0]    o_count
);

    q_state_t      r_state;
    q_state_t      w_state_nxt;
    logic [DW-1:0] r_d0;
    logic [DW-1:0] r_d1;
    logic [DW-1:0] w_d0_nxt;
    logic [DW-1:0] w_d1_nxt;
    logic          w_pop;

    assign w_pop = i_pop & (r_state != Q0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= Q0;
            r_d0    <= '0;
            r_d1    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_d0    <= w_d0_nxt;
            r_d1    <= w_d1_nxt;
        end
    end

    // Head only changes on a pop or on a push into an empty queue, so it holds while stalled
    always_comb begin
        w_state_nxt = r_state;
        w_d0_nxt    = r_d0;
        w_d1_nxt    = r_d1;
        unique case (r_state)
            Q0: begin
                if (i_push) begin
                    w_d0_nxt    = i_data;
                    w_state_nxt = Q1;
                end
            end
            Q1: begin
                if (i_push && w_pop) begin
                    w_d0_nxt = i_data;
                end else if (i_push) begin
                    w_d1_nxt    = i_data;
                    w_state_nxt = Q2;
                end else if (w_pop) begin
                    w_state_nxt = Q0;
                end
            end
            Q2: begin
                if (w_pop) begin
                    w_d0_nxt = r_d1;
                    if (i_push) begin
                        w_d1_nxt = i_data;
                    end else begin
                        w_state_nxt = Q1;
                    end
                end
            end
            default: w_state_nxt = Q0;
        endcase
    end

    assign o_head  = r_d0;
    assign o_valid = (r_state != Q0);
    assign o_count = (r_state == Q2) ? 2'd2 : ((r_state == Q1) ? 2'd1 : 2'd0);

endmodule

// File: rtl/pe_buffer_read_port.sv
// Read-side controller of the PE input circular buffer: owns raddr, issues PAR_READ-wide reads,
// streams words to the PE through a 2-entry queue. PE_RD_STATS_EN adds stall/starve counters.
module pe_buffer_read_port
    import pe_buf_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 15,
    parameter int unsigned PAR_READ  = 3,
    parameter int unsigned THRESHOLD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_buffer_read_port_if.master bus
);

    localparam int unsigned      DW      = WIDTH * PAR_READ;
    localparam logic [OCC_W-1:0] DEPTH_O = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] PAR_O   = OCC_W'(PAR_READ);
    localparam logic [OCC_W-1:0] THR_O   = OCC_W'(THRESHOLD);

    logic [PTR_W-1:0] r_raddr;
    logic             r_inflight;
    logic             r_armed;
    logic [OCC_W-1:0] w_occ;
    logic             w_armed_eff;
    logic             w_rd_en;
    logic             w_pop;
    logic             w_q_valid;
    logic [1:0]       w_q_count;
    logic [2:0]       w_pending;
    logic [DW-1:0]    w_q_head;

    assign w_occ = occ(bus.waddr, r_raddr, DEPTH_O);
    assign w_pop = w_q_valid & bus.m_ready;

    // Words owed to the queue after this cycle; a same-cycle pop frees its entry
    assign w_pending   = 3'(w_q_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_armed_eff = r_armed | (w_occ >= THR_O);
    assign w_rd_en     = w_armed_eff & (w_occ >= PAR_O) & (w_pending < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raddr    <= '0;
            r_inflight <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_raddr <= ptr_add(r_raddr, PAR_O, DEPTH_O);
            end
            if (w_occ >= THR_O) begin
                r_armed <= 1'b1;
            end else if ((w_occ < PAR_O) && (w_q_count == 2'd0)) begin
                r_armed <= 1'b0;
            end
        end
    end

    // Buffer data returns the cycle after rd_en and lands in the queue tail
    pe_rd_skid_q #(
        .DW(DW)
    ) u_skid_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (bus.buf_rdata),
        .i_pop   (w_pop),
        .o_head  (w_q_head),
        .o_valid (w_q_valid),
        .o_count (w_q_count)
    );

    assign bus.raddr     = r_raddr;
    assign bus.rd_en     = w_rd_en;
    assign bus.m_data    = w_q_head;
    assign bus.m_valid   = w_q_valid;
    assign bus.occupancy = w_occ;
    assign bus.empty     = (w_occ < PAR_O);

`ifdef PE_RD_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_starve_cnt;

    // Saturating counters of PE back-pressure and reader starvation cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_q_valid && !bus.m_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (r_armed && !w_q_valid && (w_occ < PAR_O) && (r_starve_cnt != 16'hFFFF)) begin
                r_starve_cnt <= r_starve_cnt + 16'd1;
            end
        end
    end

    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.starve_cnt = r_starve_cnt;
`endif

endmodule

// File: tb/tb_pe_buffer_read_port.sv
// Bench for pe_buffer_read_port: buffer model, cycle table, scoreboard of delivered words.
module tb_pe_buffer_read_port;
    import pe_buf_pkg::*;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned DEPTH     = 15;
    localparam int unsigned PAR_READ  = 3;
    localparam int unsigned THRESHOLD = 3;
    localparam int unsigned SLOTS     = DEPTH + 1;
    localparam int unsigned DW        = WIDTH * PAR_READ;
    localparam int unsigned NVEC      = 16;

    typedef struct {
        logic [3:0]    waddr;
        logic          m_ready;
        logic          rd_en;
        logic          m_valid;
        logic [3:0]    raddr;
        logic [4:0]    occ;
        logic          empty;
        logic          chk_data;
        logic [DW-1:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_buffer_read_port_if #(.WIDTH(WIDTH), .PAR_READ(PAR_READ)) bif ();

    pe_buffer_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PAR_READ(PAR_READ), .THRESHOLD(THRESHOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    logic [WIDTH-1:0] mem [SLOTS];
    logic [15:0]      val_ctr = 16'h1000;
    int unsigned      wptr = 0;
    int unsigned      exp_rptr = 0;
    logic [DW-1:0]    exp_q [$];
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               pops = 0;
    int               first_pop_cyc = 0;
    int               last_pop_cyc = 0;
    vec_t             vecs [NVEC];

    function automatic logic [DW-1:0] slots_word(input int unsigned base);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < int'(PAR_READ); k++) begin
            w[DW-1-k*WIDTH -: WIDTH] = mem[(base + k) % SLOTS];
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elems(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            mem[wptr] = val_ctr;
            val_ctr   = val_ctr + 16'd1;
            wptr      = (wptr + 1) % SLOTS;
        end
        bif.waddr = PTR_W'(wptr);
    endtask

    // Registered-read buffer model
    always @(posedge clk) begin
        if (bif.rd_en) bif.buf_rdata <= slots_word(int'(bif.raddr));
    end

    // Scoreboard: expected word queued at each read issue, compared at each handshake
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_rptr = 0;
        end else begin
            if (bif.m_valid && bif.m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h with nothing outstanding", bif.m_data);
                end else begin
                    check("word", 64'(bif.m_data), 64'(exp_q.pop_front()));
                end
                if (pops == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pops++;
            end
            if (bif.rd_en) begin
                check("raddr_at_issue", 64'(bif.raddr), 64'(exp_rptr));
                exp_q.push_back(slots_word(exp_rptr));
                exp_rptr = (exp_rptr + PAR_READ) % SLOTS;
            end
        end
    end

    initial begin
        logic [DW-1:0] held;
        int            rdcnt;
        bit            have_held;

        for (int i = 0; i < int'(SLOTS); i++) mem[i] = 16'hA000 + 16'(i);
        for (int i = 0; i < 10; i++) vecs[i] = '{4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b1, (i == 0), '0};
        vecs[10] = '{4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 5'd2, 1'b1, 1'b0, '0};
        vecs[11] = '{4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 5'd2, 1'b1, 1'b0, '0};
        vecs[12] = '{4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 5'd3, 1'b0, 1'b0, '0};
        vecs[13] = '{4'd3, 1'b1, 1'b0, 1'b0, 4'd3, 5'd0, 1'b1, 1'b0, '0};
        vecs[14] = '{4'd3, 1'b1, 1'b0, 1'b1, 4'd3, 5'd0, 1'b1, 1'b1, 48'hA000_A001_A002};
        vecs[15] = '{4'd3, 1'b1, 1'b0, 1'b0, 4'd3, 5'd0, 1'b1, 1'b0, '0};

        rst         = 1'b1;
        bif.waddr   = '0;
        bif.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset idle, then threshold arming and first-read latency
        for (int i = 0; i < int'(NVEC); i++) begin
            step();
            bif.waddr   = vecs[i].waddr;
            bif.m_ready = vecs[i].m_ready;
            @(negedge clk);
            check($sformatf("v%0d_rd_en", i),     64'(bif.rd_en),     64'(vecs[i].rd_en));
            check($sformatf("v%0d_m_valid", i),   64'(bif.m_valid),   64'(vecs[i].m_valid));
            check($sformatf("v%0d_raddr", i),     64'(bif.raddr),     64'(vecs[i].raddr));
            check($sformatf("v%0d_occupancy", i), 64'(bif.occupancy), 64'(vecs[i].occ));
            check($sformatf("v%0d_empty", i),     64'(bif.empty),     64'(vecs[i].empty));
            if (vecs[i].chk_data) check($sformatf("v%0d_m_data", i), 64'(bif.m_data), 64'(vecs[i].data));
        end
        wptr = 3;

        // Full preload streams 5 words back to back
        step();
        rst = 1'b1;
        bif.waddr = '0;
        wptr = 0;
        step();
        rst = 1'b0;
        step();
        pops = 0;
        write_elems(15);
        repeat (12) step();
        @(negedge clk);
        check("preload_pops", 64'(pops), 64'd5);
        check("preload_back_to_back", 64'(last_pop_cyc - first_pop_cyc), 64'd4);
        check("preload_raddr", 64'(bif.raddr), 64'd15);
        check("preload_empty", 64'(bif.empty), 64'd1);
        check("preload_outstanding", 64'(exp_q.size()), 64'd0);

        // Wrap-around reads: 15,0,1 then up to 14 and 14,15,0
        step();
        write_elems(3);
        repeat (8) step();
        @(negedge clk);
        check("wrap1_raddr", 64'(bif.raddr), 64'd2);
        step();
        write_elems(12);
        repeat (12) step();
        @(negedge clk);
        check("to14_raddr", 64'(bif.raddr), 64'd14);
        step();
        write_elems(3);
        @(negedge clk);
        check("wrap2_occupancy", 64'(bif.occupancy), 64'd3);
        check("wrap2_rd_en", 64'(bif.rd_en), 64'd1);
        repeat (8) step();
        @(negedge clk);
        check("wrap2_raddr", 64'(bif.raddr), 64'd1);
        check("wrap2_empty", 64'(bif.empty), 64'd1);
        check("wrap2_outstanding", 64'(exp_q.size()), 64'd0);

        // Back-pressure: queue fills to 2, head holds, no further reads
        step();
        bif.m_ready = 1'b0;
        write_elems(12);
        rdcnt = 0;
        have_held = 1'b0;
        held = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bif.rd_en) rdcnt++;
            if (bif.m_valid) begin
                if (have_held) check($sformatf("stall_hold_k%0d", k), 64'(bif.m_data), 64'(held));
                held = bif.m_data;
                have_held = 1'b1;
            end
            step();
        end
        @(negedge clk);
        check("stall_reads", 64'(rdcnt), 64'd2);
        check("stall_rd_en", 64'(bif.rd_en), 64'd0);
        check("stall_m_valid", 64'(bif.m_valid), 64'd1);
        check("stall_raddr", 64'(bif.raddr), 64'd7);
        check("stall_occupancy", 64'(bif.occupancy), 64'd6);
        check("stall_queued", 64'(exp_q.size()), 64'd2);
`ifdef PE_RD_STATS_EN
        check("stall_cnt", 64'(bif.stall_cnt), 64'd4);
`endif
        step();
        pops = 0;
        bif.m_ready = 1'b1;
        repeat (10) step();
        @(negedge clk);
        check("release_pops", 64'(pops), 64'd4);
        check("release_raddr", 64'(bif.raddr), 64'd13);
        check("release_outstanding", 64'(exp_q.size()), 64'd0);

        // Reset with a read in flight discards it
        step();
        bif.m_ready = 1'b0;
        write_elems(9);
        repeat (4) step();
        bif.m_ready = 1'b1;
        @(negedge clk);
        check("pre_rst_rd_en", 64'(bif.rd_en), 64'd1);
        step();
        bif.m_ready = 1'b0;
        rst = 1'b1;
        bif.waddr = '0;
        wptr = 0;
        @(negedge clk);
        check("rst_m_valid", 64'(bif.m_valid), 64'd0);
        check("rst_raddr", 64'(bif.raddr), 64'd0);
`ifdef PE_RD_STATS_EN
        check("rst_stall_cnt", 64'(bif.stall_cnt), 64'd0);
`endif
        step();
        rst = 1'b0;
        bif.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check($sformatf("post_rst_m_valid_k%0d", k), 64'(bif.m_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
